// File: rtl/morse_letter_scheduler_if.sv
// Letter-in / drawer / VGA pixel-port bundle for the Morse letter scheduler.
// The scheduler uses the slave view; the letter source and drawers use the master view.
interface morse_letter_scheduler_if #(
    parameter int NUM_DRAWERS = 4
);
    logic                     letter_valid;
    logic [1:0]               letter_id;
    logic                     letter_ready;
    logic [NUM_DRAWERS-1:0]   draw_go;
    logic [8*NUM_DRAWERS-1:0] drawer_x;
    logic [7*NUM_DRAWERS-1:0] drawer_y;
    logic [NUM_DRAWERS-1:0]   drawer_done;
    logic [7:0]               vga_x;
    logic [6:0]               vga_y;
    logic [2:0]               vga_colour;
    logic                     vga_plot;
    logic                     busy;
    logic                     overflow;

    modport master (
        output letter_valid, letter_id, drawer_x, drawer_y, drawer_done,
        input  letter_ready, draw_go, vga_x, vga_y, vga_colour, vga_plot, busy, overflow
    );

    modport slave (
        input  letter_valid, letter_id, drawer_x, drawer_y, drawer_done,
        output letter_ready, draw_go, vga_x, vga_y, vga_colour, vga_plot, busy, overflow
    );
endinterface

// File: rtl/morse_letter_scheduler.sv
// Queues decoded letter IDs, runs one drawer at a time onto the VGA pixel port,
// holds the finished letter, then erases its 32x32 cell.
module morse_letter_scheduler #(
    parameter int         NUM_DRAWERS = 4,
    parameter int         QDEPTH      = 4,
    parameter int         HOLD_CYCLES = 50000000,
    parameter logic [7:0] CELL_X      = 8'd58,
    parameter logic [6:0] CELL_Y      = 7'd29,
    parameter logic [2:0] DRAW_COLOUR = 3'b111
) (
    input  logic                  clk,
    input  logic                  reset,
    morse_letter_scheduler_if.slave bus
);
    localparam int AW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
    localparam int HW = (HOLD_CYCLES > 1) ? $clog2(HOLD_CYCLES) : 1;

    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_DRAW, S_HOLD, S_CLEAR} state_t;

    state_t                 state_q, state_d;
    logic [1:0]             fifo_mem [QDEPTH];
    logic [AW-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]            count_q, count_d;
    logic [1:0]             sel_q, sel_d;
    logic                   draw_seen_q, draw_seen_d;
    logic [HW-1:0]          hold_cnt_q, hold_cnt_d;
    logic [9:0]             clr_cnt_q, clr_cnt_d;
    logic [NUM_DRAWERS-1:0] draw_go_q, draw_go_d;
    logic [7:0]             vga_x_q, vga_x_d;
    logic [6:0]             vga_y_q, vga_y_d;
    logic [2:0]             vga_colour_q, vga_colour_d;
    logic                   vga_plot_q, vga_plot_d;
    logic                   overflow_q, overflow_d;

    logic [7:0] dx [NUM_DRAWERS];
    logic [6:0] dy [NUM_DRAWERS];
    logic       fifo_full, fifo_empty, push, pop, head_valid, sel_done;
    logic [1:0] head;
    logic [7:0] sel_x;
    logic [6:0] sel_y;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_DRAWERS; gi++) begin : g_unpack
            assign dx[gi] = bus.drawer_x[8*gi +: 8];
            assign dy[gi] = bus.drawer_y[7*gi +: 7];
        end
    endgenerate

    // LOAD always pops, so a full FIFO can still take a letter in that cycle.
    assign fifo_full  = (count_q == (AW+1)'(QDEPTH));
    assign fifo_empty = (count_q == '0);
    assign pop        = (state_q == S_LOAD);
    assign push       = bus.letter_valid && (!fifo_full || pop);
    assign head       = fifo_mem[rd_ptr_q];
    assign head_valid = ({1'b0, head} < 3'(NUM_DRAWERS));

    always_comb begin
        sel_x    = '0;
        sel_y    = '0;
        sel_done = 1'b0;
        for (int i = 0; i < NUM_DRAWERS; i++) begin
            if (sel_q == 2'(i)) begin
                sel_x    = dx[i];
                sel_y    = dy[i];
                sel_done = bus.drawer_done[i];
            end
        end
    end

    always_comb begin
        state_d      = state_q;
        sel_d        = sel_q;
        draw_seen_d  = draw_seen_q;
        hold_cnt_d   = hold_cnt_q;
        clr_cnt_d    = clr_cnt_q;
        draw_go_d    = '0;
        vga_x_d      = vga_x_q;
        vga_y_d      = vga_y_q;
        vga_colour_d = vga_colour_q;
        vga_plot_d   = 1'b0;
        wr_ptr_d     = wr_ptr_q + AW'(push);
        rd_ptr_d     = rd_ptr_q + AW'(pop);
        count_d      = count_q + (AW+1)'(push) - (AW+1)'(pop);
        overflow_d   = overflow_q | (bus.letter_valid & fifo_full & ~pop);

        case (state_q)
            S_IDLE: begin
                if (!fifo_empty) state_d = S_LOAD;
            end
            S_LOAD: begin
                sel_d       = head;
                draw_seen_d = 1'b0;
                if (head_valid) begin
                    state_d = S_DRAW;
                    for (int i = 0; i < NUM_DRAWERS; i++) draw_go_d[i] = (head == 2'(i));
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_DRAW: begin
                draw_seen_d = 1'b1;
                // done on the very first DRAW cycle may be left over from a previous run
                if (sel_done && draw_seen_q) begin
                    state_d    = S_HOLD;
                    hold_cnt_d = '0;
                end else begin
                    draw_go_d    = draw_go_q;
                    vga_x_d      = sel_x;
                    vga_y_d      = sel_y;
                    vga_colour_d = DRAW_COLOUR;
                    vga_plot_d   = 1'b1;
                end
            end
            S_HOLD: begin
                if (hold_cnt_q == HW'(HOLD_CYCLES - 1)) begin
                    state_d   = S_CLEAR;
                    clr_cnt_d = '0;
                end else begin
                    hold_cnt_d = hold_cnt_q + HW'(1);
                end
            end
            S_CLEAR: begin
                vga_x_d      = CELL_X + {3'b000, clr_cnt_q[4:0]};
                vga_y_d      = CELL_Y + {2'b00, clr_cnt_q[9:5]};
                vga_colour_d = 3'b000;
                vga_plot_d   = 1'b1;
                clr_cnt_d    = clr_cnt_q + 10'd1;
                if (clr_cnt_q == 10'd1023) state_d = fifo_empty ? S_IDLE : S_LOAD;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= S_IDLE;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            sel_q        <= '0;
            draw_seen_q  <= 1'b0;
            hold_cnt_q   <= '0;
            clr_cnt_q    <= '0;
            draw_go_q    <= '0;
            vga_x_q      <= '0;
            vga_y_q      <= '0;
            vga_colour_q <= '0;
            vga_plot_q   <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
            sel_q        <= sel_d;
            draw_seen_q  <= draw_seen_d;
            hold_cnt_q   <= hold_cnt_d;
            clr_cnt_q    <= clr_cnt_d;
            draw_go_q    <= draw_go_d;
            vga_x_q      <= vga_x_d;
            vga_y_q      <= vga_y_d;
            vga_colour_q <= vga_colour_d;
            vga_plot_q   <= vga_plot_d;
            overflow_q   <= overflow_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !reset) fifo_mem[wr_ptr_q] <= bus.letter_id;
    end

    assign bus.letter_ready = !fifo_full || pop;
    assign bus.draw_go      = draw_go_q;
    assign bus.vga_x        = vga_x_q;
    assign bus.vga_y        = vga_y_q;
    assign bus.vga_colour   = vga_colour_q;
    assign bus.vga_plot     = vga_plot_q;
    assign bus.busy         = (state_q != S_IDLE) || !fifo_empty;
    assign bus.overflow     = overflow_q;
endmodule

// File: tb/tb_morse_letter_scheduler.sv
// Directed bench: mock drawers emit x=58+k until done; a negedge monitor logs plots and drawer starts.
module tb_morse_letter_scheduler;
    logic clk = 1'b0;
    logic reset;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    morse_letter_scheduler_if #(.NUM_DRAWERS(4)) bus4 ();
    morse_letter_scheduler_if #(.NUM_DRAWERS(3)) bus3 ();

    morse_letter_scheduler #(.NUM_DRAWERS(4), .HOLD_CYCLES(5)) u_dut (
        .clk(clk), .reset(reset), .bus(bus4)
    );
    morse_letter_scheduler #(.NUM_DRAWERS(3), .HOLD_CYCLES(5)) u_dut3 (
        .clk(clk), .reset(reset), .bus(bus3)
    );

    // Mock drawers: drawer i outputs x=58+k, y=10+i, done once k reaches draw_len
    int         draw_len;
    logic [3:0] force_done;
    int         k [4];
    logic [31:0] mx;
    logic [27:0] my;
    logic [3:0]  md;

    always @(posedge clk) begin
        for (int i = 0; i < 4; i++) begin
            if (reset || !bus4.draw_go[i]) k[i] <= 0;
            else if (k[i] < draw_len) k[i] <= k[i] + 1;
        end
    end

    always_comb begin
        mx = '0;
        my = '0;
        md = '0;
        for (int i = 0; i < 4; i++) begin
            mx[8*i +: 8] = 8'(58 + k[i]);
            my[7*i +: 7] = 7'(10 + i);
            md[i]        = force_done[i] || (k[i] >= draw_len);
        end
    end

    assign bus4.drawer_x    = mx;
    assign bus4.drawer_y    = my;
    assign bus4.drawer_done = md;
    assign bus3.drawer_x    = '0;
    assign bus3.drawer_y    = '0;
    assign bus3.drawer_done = '0;

    // Plot / start monitor
    logic [3:0] prev_go = '0;
    int draw_xs[$];
    int draw_ys[$];
    int go_log[$];
    int clear_plots = 0;
    int last_x = 0, last_y = 0, zero_run = 0, last_gap = 0;

    function automatic int onehot_idx(input logic [3:0] v);
        int r = -1;
        for (int i = 0; i < 4; i++) if (v[i]) r = i;
        return r;
    endfunction

    always @(negedge clk) begin
        prev_go <= bus4.draw_go;
        if (bus4.draw_go != 4'b0 && prev_go == 4'b0) go_log.push_back(onehot_idx(bus4.draw_go));
        if (bus4.vga_plot) begin
            if (bus4.vga_colour == 3'b111) begin
                draw_xs.push_back(int'(bus4.vga_x));
                draw_ys.push_back(int'(bus4.vga_y));
            end else if (bus4.vga_colour == 3'b000) begin
                clear_plots <= clear_plots + 1;
                last_x      <= int'(bus4.vga_x);
                last_y      <= int'(bus4.vga_y);
                if (zero_run > 0) last_gap <= zero_run;
            end
            zero_run <= 0;
        end else begin
            zero_run <= zero_run + 1;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", tag, got, got, exp, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push(input logic [1:0] id);
        bus4.letter_valid = 1'b1;
        bus4.letter_id    = id;
        tick();
        bus4.letter_valid = 1'b0;
        $display("push id=%0d ready=%0b overflow=%0b", id, bus4.letter_ready, bus4.overflow);
    endtask

    task automatic wait_idle(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (!bus4.busy) break;
            tick();
        end
        check(tag, 32'(bus4.busy), 32'd0);
        tick();
    endtask

    task automatic wait_go(input string tag);
        for (int i = 0; i < 10; i++) begin
            if (bus4.draw_go != 4'b0) break;
            tick();
        end
        check(tag, 32'(bus4.draw_go != 4'b0), 32'd1);
    endtask

    initial begin
        int d0, c0, g0, bad, cnt;
        int exp_order [5] = '{0, 1, 2, 3, 0};
        bit found;

        reset             = 1'b1;
        draw_len          = 32;
        force_done        = 4'b0;
        bus4.letter_valid = 1'b0;
        bus4.letter_id    = 2'd0;
        bus3.letter_valid = 1'b0;
        bus3.letter_id    = 2'd0;
        repeat (3) tick();
        reset = 1'b0;

        // Reset state
        check("rst_go", 32'(bus4.draw_go), 32'd0);
        check("rst_vga", {13'd0, bus4.vga_x, bus4.vga_y, bus4.vga_colour, bus4.vga_plot}, 32'd0);
        check("rst_busy", 32'(bus4.busy), 32'd0);
        check("rst_ovf", 32'(bus4.overflow), 32'd0);
        check("rst_ready", 32'(bus4.letter_ready), 32'd1);

        // Test 1: single letter, latency, draw pass-through, hold, clear sweep
        d0 = draw_xs.size();
        c0 = clear_plots;
        push(2'd0);
        check("t1_busy", 32'(bus4.busy), 32'd1);
        check("t1_go_n", 32'(bus4.draw_go), 32'd0);
        tick();
        check("t1_go_n1", 32'(bus4.draw_go), 32'd0);
        tick();
        check("t1_go_n2", 32'(bus4.draw_go), 32'b0001);
        tick();
        check("t1_first_plot", {23'd0, bus4.vga_plot, bus4.vga_x}, {23'd0, 1'b1, 8'd58});
        wait_idle("t1_idle_timeout", 1300);
        check("t1_draw_plots", 32'(draw_xs.size() - d0), 32'd32);
        bad = 0;
        for (int j = 0; j < 32 && d0 + j < draw_xs.size(); j++) begin
            if (draw_xs[d0 + j] != 58 + j || draw_ys[d0 + j] != 10) bad++;
        end
        check("t1_draw_seq_bad", 32'(bad), 32'd0);
        check("t1_gap", 32'(last_gap), 32'd6);
        check("t1_clear_plots", 32'(clear_plots - c0), 32'd1024);
        check("t1_last_px", {last_x[15:0], last_y[15:0]}, {16'd89, 16'd60});
        $display("t1 letter: draw=%0d clear=%0d gap=%0d", draw_xs.size() - d0, clear_plots - c0, last_gap);

        // Test 2: fill FIFO while drawing, overflow, draw order
        g0 = go_log.size();
        push(2'd0);
        wait_go("t2_go_timeout");
        push(2'd1);
        push(2'd2);
        push(2'd3);
        push(2'd0);
        check("t2_ready_full", 32'(bus4.letter_ready), 32'd0);
        check("t2_ovf_before", 32'(bus4.overflow), 32'd0);
        push(2'd2);
        check("t2_ovf_after", 32'(bus4.overflow), 32'd1);
        wait_idle("t2_idle_timeout", 6000);
        check("t2_letters", 32'(go_log.size() - g0), 32'd5);
        for (int j = 0; j < 5 && g0 + j < go_log.size(); j++) begin
            check($sformatf("t2_order%0d", j), 32'(go_log[g0 + j]), 32'(exp_order[j]));
        end

        // Test 4: done already high before draw_go -> DRAW lasts exactly 2 cycles
        force_done = 4'b0010;
        d0  = draw_xs.size();
        cnt = 0;
        push(2'd1);
        for (int j = 0; j < 10; j++) begin
            if (bus4.draw_go == 4'b0010) cnt++;
            tick();
        end
        check("t4_go_cycles", 32'(cnt), 32'd2);
        check("t4_draw_plots", 32'(draw_xs.size() - d0), 32'd1);
        wait_idle("t4_idle_timeout", 1300);
        force_done = 4'b0;

        // Test 3: push into a full FIFO during LOAD
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("t3_ovf_rst", 32'(bus4.overflow), 32'd0);
        push(2'd0);
        wait_go("t3_go_timeout");
        push(2'd1);
        push(2'd2);
        push(2'd3);
        push(2'd0);
        check("t3_ready_full", 32'(bus4.letter_ready), 32'd0);
        found = 1'b0;
        for (int j = 0; j < 1300; j++) begin
            if (bus4.vga_plot && bus4.vga_colour == 3'b000 &&
                bus4.vga_x == 8'd89 && bus4.vga_y == 7'd60) begin
                found = 1'b1;
                break;
            end
            tick();
        end
        check("t3_load_timeout", 32'(found), 32'd1);
        check("t3_ready_load", 32'(bus4.letter_ready), 32'd1);
        bus4.letter_valid = 1'b1;
        bus4.letter_id    = 2'd2;
        tick();
        bus4.letter_valid = 1'b0;
        $display("t3 push in LOAD: ready=%0b overflow=%0b go=%b", bus4.letter_ready, bus4.overflow, bus4.draw_go);
        check("t3_ready_after", 32'(bus4.letter_ready), 32'd0);
        check("t3_ovf_after", 32'(bus4.overflow), 32'd0);
        check("t3_go_next", 32'(bus4.draw_go), 32'b0010);

        // Test 5: reset mid-DRAW aborts and discards queue
        tick();
        reset = 1'b1;
        tick();
        check("t5_go", 32'(bus4.draw_go), 32'd0);
        check("t5_plot", 32'(bus4.vga_plot), 32'd0);
        check("t5_busy", 32'(bus4.busy), 32'd0);
        reset = 1'b0;
        tick();
        tick();
        check("t5_busy_after", 32'(bus4.busy), 32'd0);
        check("t5_ready_after", 32'(bus4.letter_ready), 32'd1);
        check("t5_go_after", 32'(bus4.draw_go), 32'd0);

        // Test 6: out-of-range id on a 3-drawer scheduler is dropped
        bus3.letter_valid = 1'b1;
        bus3.letter_id    = 2'd3;
        tick();
        bus3.letter_valid = 1'b0;
        check("t6_busy", 32'(bus3.busy), 32'd1);
        cnt = 0;
        for (int j = 0; j < 8; j++) begin
            if (bus3.draw_go != 3'b0 || bus3.vga_plot) cnt++;
            tick();
        end
        $display("t6 id=3 on 3 drawers: activity=%0d busy=%0b", cnt, bus3.busy);
        check("t6_activity", 32'(cnt), 32'd0);
        check("t6_idle", 32'(bus3.busy), 32'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
